chimp_game_ctrl: RTL and testbench

Game controller and board store for the chimp-test display. It places numbers 1..N in random cells of the 3x3 grid, moves the player cursor, and judges player selections. It drives the game-phase code, the cursor position and a registered per-pixel cell lookup (`row`/`col`/`number`) that the cell renderer consumes. The block owns the board; the renderer only reads it.

---
 rtl/chimp_game_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_chimp_game_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chimp_game_ctrl.sv
// Chimp-test game controller: owns the 3x3 board, fills it from an LFSR,
// moves the cursor, judges selections and serves a registered per-pixel cell lookup.
module chimp_game_ctrl #(
    parameter int           START_COUNT = 3,
    parameter int           WIN_CYCLES  = 100_000_000,
    parameter logic [15:0]  SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic [3:0] number,
    output logic [1:0] p_row,
    output logic [1:0] p_col,
    output logic [1:0] state,
    output logic [3:0] level
);

    // Buttons are single-cycle pulses; each is acted on only in the cycle it is high,
    // there is no ready/back-pressure, and at most one action is taken per cycle.
    typedef enum logic [2:0] {
        S_CLEAR,
        S_FILL,
        S_SHOW,
        S_HIDE,
        S_WIN,
        S_LOSE
    } fsm_e;

    localparam logic [3:0]  START_N  = 4'(START_COUNT);
    localparam logic [31:0] WIN_LAST = 32'(WIN_CYCLES - 1);

    fsm_e        state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  board_q [9];
    logic [3:0]  board_d [9];
    logic [3:0]  level_q, level_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  exp_q, exp_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  pr_q, pr_d;
    logic [1:0]  pc_q, pc_d;
    logic [1:0]  row_q, col_q;
    logic [3:0]  number_q;

    logic [1:0]  row_c, col_c;
    logic [3:0]  pix_idx;
    logic [3:0]  cur_idx;
    logic [3:0]  cand;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [1:0] dec3(input logic [1:0] v);
        return (v == 2'd0) ? 2'd2 : v - 2'd1;
    endfunction

    assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign cand    = lfsr_q[3:0];
    assign cur_idx = {2'b00, pr_q} * 4'd3 + {2'b00, pc_q};

    assign col_c   = (x >= 10'd426) ? 2'd2 : (x >= 10'd213) ? 2'd1 : 2'd0;
    assign row_c   = (y >= 10'd320) ? 2'd2 : (y >= 10'd160) ? 2'd1 : 2'd0;
    assign pix_idx = {2'b00, row_c} * 4'd3 + {2'b00, col_c};

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        k_d     = k_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        pc_d    = pc_q;
        board_d = board_q;
        case (state_q)
            S_CLEAR: begin
                for (int i = 0; i < 9; i++) board_d[i] = 4'd0;
                k_d     = 4'd1;
                state_d = S_FILL;
            end
            S_FILL: begin
                if (cand < 4'd9 && board_q[cand] == 4'd0) begin
                    board_d[cand] = k_q;
                    if (k_q == level_q) begin
                        exp_d   = 4'd1;
                        state_d = S_SHOW;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            // expect is never 0 here, so selecting an empty cell always loses.
            S_SHOW, S_HIDE: begin
                if (btn_sel) begin
                    if (board_q[cur_idx] == exp_q) begin
                        board_d[cur_idx] = 4'd0;
                        exp_d            = exp_q + 4'd1;
                        if (exp_q == level_q) begin
                            cnt_d   = 32'd0;
                            state_d = S_WIN;
                        end else begin
                            state_d = S_HIDE;
                        end
                    end else begin
                        state_d = S_LOSE;
                    end
                end else if (btn_up) begin
                    pr_d = dec3(pr_q);
                end else if (btn_down) begin
                    pr_d = inc3(pr_q);
                end else if (btn_left) begin
                    pc_d = dec3(pc_q);
                end else if (btn_right) begin
                    pc_d = inc3(pc_q);
                end
            end
            S_WIN: begin
                if (cnt_q == WIN_LAST) begin
                    level_d = (level_q >= 4'd9) ? 4'd9 : level_q + 4'd1;
                    state_d = S_CLEAR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_LOSE: begin
                if (btn_sel) begin
                    level_d = START_N;
                    state_d = S_CLEAR;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_CLEAR;
            lfsr_q   <= SEED;
            for (int i = 0; i < 9; i++) board_q[i] <= 4'd0;
            level_q  <= START_N;
            k_q      <= 4'd1;
            exp_q    <= 4'd1;
            cnt_q    <= 32'd0;
            pr_q     <= 2'd0;
            pc_q     <= 2'd0;
            row_q    <= 2'd0;
            col_q    <= 2'd0;
            number_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            board_q  <= board_d;
            level_q  <= level_d;
            k_q      <= k_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            pr_q     <= pr_d;
            pc_q     <= pc_d;
            row_q    <= row_c;
            col_q    <= col_c;
            number_q <= board_q[pix_idx];
        end
    end

    always_comb begin
        case (state_q)
            S_SHOW:  state = 2'd0;
            S_HIDE:  state = 2'd1;
            S_WIN:   state = 2'd2;
            default: state = 2'd3;
        endcase
    end

    assign row    = row_q;
    assign col    = col_q;
    assign number = number_q;
    assign p_row  = pr_q;
    assign p_col  = pc_q;
    assign level  = level_q;

endmodule

// File: tb/tb_chimp_game_ctrl.sv
// Directed bench for chimp_game_ctrl: fill, cursor wrap, win/lose flow,
// lookup boundaries, level cap and reset during WIN.
module tb_chimp_game_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic [9:0] x, y;
    logic [1:0] row, col, p_row, p_col, state;
    logic [3:0] number, level;

    int n_vec;
    int n_err;
    logic [3:0] tb_board [9];
    int exp_pr, exp_pc, exp_level;

    chimp_game_ctrl #(.START_COUNT(3), .WIN_CYCLES(4), .SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel),
        .x(x), .y(y),
        .row(row), .col(col), .number(number),
        .p_row(p_row), .p_col(p_col), .state(state), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic press(input logic u, input logic d, input logic l, input logic r, input logic s);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
        @(negedge clk);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
    endtask

    task automatic wait_state(input logic [1:0] code, input int budget, input string name);
        int n;
        n = 0;
        while (state !== code && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (state !== code) begin
            n_err++;
            $display("FAIL %s: state=%0d required=%0d (timeout %0d cycles)", name, state, code, budget);
        end
    endtask

    task automatic scan_board();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                x = 10'(c * 213 + 100);
                y = 10'(r * 160 + 80);
                @(negedge clk);
                n_vec++;
                if (row !== 2'(r) || col !== 2'(c)) begin
                    n_err++;
                    $display("FAIL scan_rowcol: row=%0d col=%0d required=%0d,%0d", row, col, r, c);
                end
                tb_board[r * 3 + c] = number;
            end
        end
    endtask

    task automatic check_perm(input int n, input string name);
        int cnt [10];
        logic ok;
        for (int v = 0; v < 10; v++) cnt[v] = 0;
        ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (tb_board[i] > 4'd9) ok = 1'b0;
            else cnt[tb_board[i]]++;
        end
        for (int v = 1; v < 10; v++) begin
            if (v <= n && cnt[v] != 1) ok = 1'b0;
            if (v > n && cnt[v] != 0) ok = 1'b0;
        end
        if (cnt[0] != 9 - n) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: board=%0d %0d %0d %0d %0d %0d %0d %0d %0d required 1..%0d once, rest 0",
                     name, tb_board[0], tb_board[1], tb_board[2], tb_board[3], tb_board[4],
                     tb_board[5], tb_board[6], tb_board[7], tb_board[8], n);
        end
    endtask

    function automatic int find_cell(input int v);
        for (int i = 0; i < 9; i++) if (tb_board[i] == 4'(v)) return i;
        return -1;
    endfunction

    task automatic goto_cell(input int idx);
        while (exp_pr != idx / 3) begin
            press(0, 1, 0, 0, 0);
            exp_pr = (exp_pr + 1) % 3;
        end
        while (exp_pc != idx % 3) begin
            press(0, 0, 0, 1, 0);
            exp_pc = (exp_pc + 1) % 3;
        end
        n_vec++;
        if (p_row !== 2'(exp_pr) || p_col !== 2'(exp_pc)) begin
            n_err++;
            $display("FAIL goto: p_row=%0d p_col=%0d required=%0d,%0d", p_row, p_col, exp_pr, exp_pc);
        end
    endtask

    // Selects 1..n in order; leaves the FSM in the first WIN cycle.
    task automatic win_round(input int n);
        int idx;
        for (int v = 1; v <= n; v++) begin
            idx = find_cell(v);
            if (idx < 0) begin
                n_vec++; n_err++;
                $display("FAIL win_round_find: value %0d not on board, required present", v);
                return;
            end
            goto_cell(idx);
            press(0, 0, 0, 0, 1);
            n_vec++;
            if (state !== ((v == n) ? 2'd2 : 2'd1)) begin
                n_err++;
                $display("FAIL win_round_sel: after selecting %0d state=%0d required=%0d",
                         v, state, (v == n) ? 2 : 1);
            end
        end
    endtask

    task automatic check_level(input int lv, input string name);
        n_vec++;
        if (level !== 4'(lv)) begin
            n_err++;
            $display("FAIL %s: level=%0d required=%0d", name, level, lv);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (state !== 2'd3 || level !== 4'd3 || p_row !== 2'd0 || p_col !== 2'd0 ||
            row !== 2'd0 || col !== 2'd0 || number !== 4'd0) begin
            n_err++;
            $display("FAIL reset_values: state=%0d level=%0d p=%0d,%0d rc=%0d,%0d num=%0d required 3 3 0,0 0,0 0",
                     state, level, p_row, p_col, row, col, number);
        end
        reset = 1'b0;
        exp_pr = 0; exp_pc = 0; exp_level = 3;
    endtask

    task automatic test_fill();
        wait_state(2'd0, 2000, "fill_to_show");
        check_level(3, "fill_level");
        n_vec++;
        if (p_row !== 2'd0 || p_col !== 2'd0) begin
            n_err++;
            $display("FAIL fill_cursor: p=%0d,%0d required 0,0", p_row, p_col);
        end
        scan_board();
        check_perm(3, "fill_perm3");
    endtask

    task automatic test_cursor();
        press(1, 0, 0, 0, 0);
        n_vec++;
        if (p_row !== 2'd2) begin n_err++; $display("FAIL cursor_up_wrap: p_row=%0d required=2", p_row); end
        press(0, 0, 1, 0, 0);
        n_vec++;
        if (p_col !== 2'd2) begin n_err++; $display("FAIL cursor_left_wrap: p_col=%0d required=2", p_col); end
        for (int i = 0; i < 3; i++) press(0, 1, 0, 0, 0);
        n_vec++;
        if (p_row !== 2'd2) begin n_err++; $display("FAIL cursor_down3: p_row=%0d required=2", p_row); end
        press(1, 0, 0, 1, 0);
        n_vec++;
        if (p_row !== 2'd1 || p_col !== 2'd2 || state !== 2'd0) begin
            n_err++;
            $display("FAIL cursor_priority: p=%0d,%0d state=%0d required 1,2 state 0", p_row, p_col, state);
        end
        exp_pr = 1; exp_pc = 2;
    endtask

    task automatic test_correct_sequence();
        int idx;
        idx = find_cell(1);
        if (idx >= 0) begin
            goto_cell(idx);
            press(0, 0, 0, 0, 1);
            n_vec++;
            if (state !== 2'd1) begin n_err++; $display("FAIL seq_first_sel: state=%0d required=1", state); end
            x = 10'((idx % 3) * 213 + 100);
            y = 10'((idx / 3) * 160 + 80);
            @(negedge clk);
            n_vec++;
            if (number !== 4'd0) begin n_err++; $display("FAIL seq_cell_cleared: number=%0d required=0", number); end
        end
        for (int v = 2; v <= 3; v++) begin
            idx = find_cell(v);
            if (idx < 0) continue;
            goto_cell(idx);
            press(0, 0, 0, 0, 1);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (state !== 2'd2) begin n_err++; $display("FAIL seq_win_hold: cycle %0d state=%0d required=2", i, state); end
            @(negedge clk);
        end
        n_vec++;
        if (state !== 2'd3) begin n_err++; $display("FAIL seq_win_end: state=%0d required=3", state); end
        exp_level = 4;
        wait_state(2'd0, 2000, "seq_refill");
        check_level(4, "seq_level4");
        scan_board();
        check_perm(4, "seq_perm4");
    endtask

    task automatic test_wrong_selection();
        int idx;
        idx = find_cell(1);
        if (idx >= 0) begin
            goto_cell(idx);
            press(0, 0, 0, 0, 1);
        end
        idx = find_cell(3);
        if (idx >= 0) begin
            goto_cell(idx);
            press(0, 0, 0, 0, 1);
        end
        n_vec++;
        if (state !== 2'd3) begin n_err++; $display("FAIL wrong_sel: state=%0d required=3", state); end
        press(1, 0, 0, 0, 0);
        press(0, 0, 1, 0, 0);
        press(0, 1, 0, 1, 0);
        n_vec++;
        if (p_row !== 2'(exp_pr) || p_col !== 2'(exp_pc)) begin
            n_err++;
            $display("FAIL lose_moves_ignored: p=%0d,%0d required %0d,%0d", p_row, p_col, exp_pr, exp_pc);
        end
        press(0, 0, 0, 0, 1);
        exp_level = 3;
        wait_state(2'd0, 2000, "lose_refill");
        check_level(3, "lose_level3");
        scan_board();
        check_perm(3, "lose_perm3");
    endtask

    task automatic test_lookup_bounds();
        int vx [3];
        int vy [3];
        int er [3];
        vx[0] = 212; vy[0] = 159; er[0] = 0;
        vx[1] = 213; vy[1] = 160; er[1] = 1;
        vx[2] = 639; vy[2] = 479; er[2] = 2;
        for (int i = 0; i < 3; i++) begin
            x = 10'(vx[i]);
            y = 10'(vy[i]);
            @(negedge clk);
            n_vec++;
            if (row !== 2'(er[i]) || col !== 2'(er[i])) begin
                n_err++;
                $display("FAIL lookup_bound(%0d,%0d): row=%0d col=%0d required %0d,%0d",
                         vx[i], vy[i], row, col, er[i], er[i]);
            end
        end
    endtask

    task automatic test_level_cap();
        while (exp_level < 9) begin
            win_round(exp_level);
            exp_level++;
            wait_state(2'd0, 2000, "cap_refill");
            check_level(exp_level, "cap_level");
            scan_board();
            check_perm(exp_level, "cap_perm");
        end
        win_round(9);
        wait_state(2'd0, 2000, "cap_refill9");
        check_level(9, "cap_level_stays9");
        scan_board();
        check_perm(9, "cap_perm9");
    endtask

    task automatic test_reset_mid_win();
        win_round(9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (state !== 2'd3 || level !== 4'd3 || p_row !== 2'd0 || p_col !== 2'd0) begin
            n_err++;
            $display("FAIL reset_mid_win: state=%0d level=%0d p=%0d,%0d required 3 3 0,0",
                     state, level, p_row, p_col);
        end
        exp_pr = 0; exp_pc = 0; exp_level = 3;
        wait_state(2'd0, 2000, "reset_refill");
        check_level(3, "reset_level3");
        scan_board();
        check_perm(3, "reset_perm3");
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
        x = 10'd0; y = 10'd0;
        for (int i = 0; i < 9; i++) tb_board[i] = 4'd0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_cursor();
        test_correct_sequence();
        test_wrong_selection();
        test_lookup_bounds();
        test_level_cap();
        test_reset_mid_win();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
